// File: rtl/uart_rx_datapath_if.sv
// Control/status bundle between the UART Rx datapath and its FSM/core side.
// The datapath takes the slave modport; the FSM/core side takes the master modport.
interface uart_rx_datapath_if;
    logic       rst_BR;
    logic       rst_bit_counter;
    logic       bit_count_enable;
    logic       sample_o;
    logic       enable_out_reg;
    logic       clr_rx_flag;
    logic       rx_sync;
    logic       end_half_time_o;
    logic       end_bit_time_o;
    logic [3:0] Rx_bit_Count;
    logic [7:0] Rx_Data;
    logic       parity_error;
    logic       framing_error;
    logic       overrun_error;
    logic       rx_ready;

    modport master (
        output rst_BR, rst_bit_counter, bit_count_enable, sample_o, enable_out_reg, clr_rx_flag,
        input  rx_sync, end_half_time_o, end_bit_time_o, Rx_bit_Count,
        input  Rx_Data, parity_error, framing_error, overrun_error, rx_ready
    );

    modport slave (
        input  rst_BR, rst_bit_counter, bit_count_enable, sample_o, enable_out_reg, clr_rx_flag,
        output rx_sync, end_half_time_o, end_bit_time_o, Rx_bit_Count,
        output Rx_Data, parity_error, framing_error, overrun_error, rx_ready
    );
endinterface

// File: rtl/uart_rx_datapath.sv
// UART receive datapath: rx synchronizer, baud ticks, bit counter, 9-bit shifter,
// stop-bit capture and the flagged output register read by the core.
module uart_rx_datapath #(
    parameter int BIT_CYCLES = 87,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    uart_rx_datapath_if.slave bus
);
    localparam logic [15:0] LAST_CNT = 16'(BIT_CYCLES - 1);
    localparam logic [15:0] HALF_CNT = 16'(BIT_CYCLES / 2 - 1);

    logic       sync1;
    logic       sync2;
    logic [15:0] cnt;
    logic       end_half;
    logic       end_bit;
    logic [3:0] bit_cnt;
    logic [8:0] shreg;
    logic       stop_bit;
    logic [7:0] data_q;
    logic       parity_err_q;
    logic       framing_err_q;
    logic       overrun_q;
    logic       ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!bus.rst_BR) begin
            cnt <= '0;
        end else if (cnt == LAST_CNT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Ticks are gated by rst_BR so a held baud counter can never fire the FSM.
    assign end_half = (cnt == HALF_CNT) && bus.rst_BR;
    assign end_bit  = (cnt == LAST_CNT) && bus.rst_BR;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
        end else if (!bus.rst_bit_counter) begin
            bit_cnt <= '0;
        end else if (bus.bit_count_enable && (bit_cnt != 4'd15)) begin
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
        end else if (bus.sample_o) begin
            shreg <= {sync2, shreg[8:1]};
        end
    end

    // Stop bit is sampled at its mid-point, once 8 data bits plus parity are in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop_bit <= 1'b1;
        end else if (end_half && (bit_cnt == 4'd9) && bus.rst_bit_counter) begin
            stop_bit <= sync2;
        end
    end

    // A load that coincides with a clear means the old byte was consumed, so no overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q        <= '0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            ready_q       <= 1'b0;
        end else if (bus.enable_out_reg) begin
            data_q        <= shreg[7:0];
            parity_err_q  <= (^shreg) ^ PARITY_ODD;
            framing_err_q <= ~stop_bit;
            ready_q       <= 1'b1;
            overrun_q     <= bus.clr_rx_flag ? 1'b0 : (overrun_q | ready_q);
        end else if (bus.clr_rx_flag) begin
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end
    end

    assign bus.rx_sync         = sync2;
    assign bus.end_half_time_o = end_half;
    assign bus.end_bit_time_o  = end_bit;
    assign bus.Rx_bit_Count    = bit_cnt;
    assign bus.Rx_Data         = data_q;
    assign bus.parity_error    = parity_err_q;
    assign bus.framing_error   = framing_err_q;
    assign bus.overrun_error   = overrun_q;
    assign bus.rx_ready        = ready_q;
endmodule

// File: tb/tb_uart_rx_datapath.sv
// Bench for uart_rx_datapath: plays the Rx FSM against an even- and an odd-parity
// instance, with table-driven frames and a scoreboard of expected latched results.
module tb_uart_rx_datapath;
    localparam int BC = 8;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    logic abort;

    uart_rx_datapath_if bus_e ();
    uart_rx_datapath_if bus_o ();

    uart_rx_datapath #(.BIT_CYCLES(BC), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst(rst), .rx(rx), .bus(bus_e)
    );
    uart_rx_datapath #(.BIT_CYCLES(BC), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .rx(rx), .bus(bus_o)
    );

    assign bus_o.rst_BR           = bus_e.rst_BR;
    assign bus_o.rst_bit_counter  = bus_e.rst_bit_counter;
    assign bus_o.bit_count_enable = bus_e.bit_count_enable;
    assign bus_o.sample_o         = bus_e.sample_o;
    assign bus_o.enable_out_reg   = bus_e.enable_out_reg;
    assign bus_o.clr_rx_flag      = bus_e.clr_rx_flag;

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_perr;
        logic       exp_perr_odd;
        logic       exp_ferr;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       perr_odd;
        logic       ferr;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_clr();
        bus_e.clr_rx_flag = 1'b1;
        @(posedge clk); #1;
        bus_e.clr_rx_flag = 1'b0;
    endtask

    // Drives one serial frame while acting as the Rx FSM; abort_after > 0 stops after that many samples.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input bit clr_on_load, input logic ready_before, input int abort_after);
        logic [10:0] bits;
        int guard;
        int samples;
        bits    = {s, p, d, 1'b0};
        abort   = 1'b0;
        samples = 0;
        fork
            begin : driver
                for (int i = 0; i < 11 && !abort; i++) begin
                    rx = bits[i];
                    for (int c = 0; c < BC && !abort; c++) begin
                        @(posedge clk); #1;
                    end
                end
                rx = 1'b1;
            end
            begin : fsm
                guard = 0;
                while (bus_e.rx_sync !== 1'b0 && guard < 20) begin
                    @(negedge clk);
                    guard++;
                end
                if (bus_e.rx_sync !== 1'b0) begin
                    check("start_detect_timeout", 8'(bus_e.rx_sync), 8'h0);
                    abort = 1'b1;
                end else begin
                    @(posedge clk); #1;
                    bus_e.rst_BR          = 1'b1;
                    bus_e.rst_bit_counter = 1'b1;
                    for (int t = 0; t < 11 && !abort; t++) begin
                        guard = 0;
                        do begin
                            @(negedge clk);
                            guard++;
                        end while (bus_e.end_half_time_o !== 1'b1 && guard < 2 * BC);
                        if (bus_e.end_half_time_o !== 1'b1) begin
                            check("half_tick_timeout", 8'(bus_e.end_half_time_o), 8'h1);
                            abort = 1'b1;
                        end else begin
                            @(posedge clk); #1;
                            if (t >= 1 && t <= 9) begin
                                bus_e.sample_o         = 1'b1;
                                bus_e.bit_count_enable = 1'b1;
                                @(posedge clk); #1;
                                bus_e.sample_o         = 1'b0;
                                bus_e.bit_count_enable = 1'b0;
                                samples++;
                                if (samples == abort_after) abort = 1'b1;
                            end else if (t == 10) begin
                                bus_e.enable_out_reg = 1'b1;
                                bus_e.clr_rx_flag    = clr_on_load;
                                @(negedge clk);
                                check("ready_before_load", 8'(bus_e.rx_ready), 8'(ready_before));
                                @(posedge clk); #1;
                                bus_e.enable_out_reg  = 1'b0;
                                bus_e.clr_rx_flag     = 1'b0;
                                bus_e.rst_BR          = 1'b0;
                                bus_e.rst_bit_counter = 1'b0;
                            end
                        end
                    end
                end
            end
        join
    endtask

    task automatic apply_stimulus(input vec_t v, input logic ready_before, input bit clr_on_load);
        sb.push_back('{v.data, v.exp_perr, v.exp_perr_odd, v.exp_ferr});
        send_frame(v.data, v.par, v.stop, clr_on_load, ready_before, -1);
    endtask

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 8'(sb.size()), 8'h1);
        end else begin
            e = sb.pop_front();
            check($sformatf("data_%02h", e.data), bus_e.Rx_Data, e.data);
            check($sformatf("data_odd_%02h", e.data), bus_o.Rx_Data, e.data);
            check($sformatf("perr_%02h", e.data), 8'(bus_e.parity_error), 8'(e.perr));
            check($sformatf("perr_odd_%02h", e.data), 8'(bus_o.parity_error), 8'(e.perr_odd));
            check($sformatf("ferr_%02h", e.data), 8'(bus_e.framing_error), 8'(e.ferr));
            check($sformatf("ferr_odd_%02h", e.data), 8'(bus_o.framing_error), 8'(e.ferr));
            check($sformatf("ready_%02h", e.data), 8'(bus_e.rx_ready), 8'h1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst                    = 1'b0;
        rx                     = 1'b1;
        abort                  = 1'b0;
        bus_e.rst_BR           = 1'b0;
        bus_e.rst_bit_counter  = 1'b0;
        bus_e.bit_count_enable = 1'b0;
        bus_e.sample_o         = 1'b0;
        bus_e.enable_out_reg   = 1'b0;
        bus_e.clr_rx_flag      = 1'b0;

        #12;
        check("rst_rx_sync", 8'(bus_e.rx_sync), 8'h1);
        check("rst_half", 8'(bus_e.end_half_time_o), 8'h0);
        check("rst_bit", 8'(bus_e.end_bit_time_o), 8'h0);
        check("rst_count", 8'(bus_e.Rx_bit_Count), 8'h0);
        check("rst_data", bus_e.Rx_Data, 8'h00);
        check("rst_perr", 8'(bus_e.parity_error), 8'h0);
        check("rst_ferr", 8'(bus_e.framing_error), 8'h0);
        check("rst_overrun", 8'(bus_e.overrun_error), 8'h0);
        check("rst_ready", 8'(bus_e.rx_ready), 8'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Baud ticks after releasing the hold.
        bus_e.rst_BR = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            check($sformatf("half_tick_c%0d", k), 8'(bus_e.end_half_time_o), 8'((k % 8) == 4));
            check($sformatf("bit_tick_c%0d", k), 8'(bus_e.end_bit_time_o), 8'((k % 8) == 0));
        end
        repeat (4) @(posedge clk);
        #1;
        bus_e.rst_BR = 1'b0;
        #1;
        check("half_tick_gated", 8'(bus_e.end_half_time_o), 8'h0);
        @(posedge clk); #1;

        // Bit counter saturation and clear priority.
        bus_e.rst_bit_counter  = 1'b1;
        bus_e.bit_count_enable = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        check("count_9", 8'(bus_e.Rx_bit_Count), 8'd9);
        repeat (11) @(posedge clk);
        #1;
        check("count_saturate", 8'(bus_e.Rx_bit_Count), 8'd15);
        bus_e.rst_bit_counter = 1'b0;
        @(posedge clk); #1;
        check("count_clear_wins", 8'(bus_e.Rx_bit_Count), 8'd0);
        bus_e.bit_count_enable = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            pulse_clr();
            apply_stimulus(vecs[i], 1'b0, 1'b0);
            check_output();
            check($sformatf("overrun_vec%0d", i), 8'(bus_e.overrun_error), 8'h0);
            repeat (2) @(posedge clk);
            #1;
        end

        // Overrun, clear, and clear coinciding with a load.
        pulse_clr();
        apply_stimulus('{8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}, 1'b0, 1'b0);
        check_output();
        apply_stimulus('{8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}, 1'b1, 1'b0);
        check_output();
        check("overrun_set", 8'(bus_e.overrun_error), 8'h1);
        pulse_clr();
        check("clr_ready", 8'(bus_e.rx_ready), 8'h0);
        check("clr_overrun", 8'(bus_e.overrun_error), 8'h0);
        check("clr_data_hold", bus_e.Rx_Data, 8'h22);
        apply_stimulus('{8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}, 1'b0, 1'b0);
        check_output();
        apply_stimulus('{8'h44, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}, 1'b1, 1'b0);
        check_output();
        check("overrun_set2", 8'(bus_e.overrun_error), 8'h1);
        apply_stimulus('{8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}, 1'b1, 1'b1);
        check_output();
        check("clr_with_load_overrun", 8'(bus_e.overrun_error), 8'h0);

        // Reset in the middle of a frame.
        send_frame(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 4);
        check("abort_count", 8'(bus_e.Rx_bit_Count), 8'd4);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_rx_sync", 8'(bus_e.rx_sync), 8'h1);
        check("mid_rst_half", 8'(bus_e.end_half_time_o), 8'h0);
        check("mid_rst_bit", 8'(bus_e.end_bit_time_o), 8'h0);
        check("mid_rst_count", 8'(bus_e.Rx_bit_Count), 8'h0);
        check("mid_rst_data", bus_e.Rx_Data, 8'h00);
        check("mid_rst_perr_odd", 8'(bus_o.parity_error), 8'h0);
        check("mid_rst_ferr", 8'(bus_e.framing_error), 8'h0);
        check("mid_rst_overrun", 8'(bus_e.overrun_error), 8'h0);
        check("mid_rst_ready", 8'(bus_e.rx_ready), 8'h0);
        bus_e.rst_BR           = 1'b0;
        bus_e.rst_bit_counter  = 1'b0;
        bus_e.sample_o         = 1'b0;
        bus_e.bit_count_enable = 1'b0;
        rx                     = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        apply_stimulus('{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}, 1'b0, 1'b0);
        check_output();
        check("after_rst_overrun", 8'(bus_e.overrun_error), 8'h0);
        check("sb_drained", 8'(sb.size()), 8'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_datapath.md
# uart_rx_datapath

Receive datapath paired with the UART Rx control FSM. It synchronizes the serial `rx` line and generates the half-bit and full-bit baud ticks. It also counts sampled bits, shifts in 8 data bits plus 1 parity bit LSB-first, and checks the stop bit. On the FSM's save strobe it latches the byte with parity, framing and overrun status into a flagged output register for the core's MMIO read.

## Interface
Parameters:
- `BIT_CYCLES`, default 87: clock cycles per bit (10 MHz / 115200). Legal range is 4..65535.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  reset, asynchronous, active-low.
- `rx`  input  1  raw serial line, asynchronous to `clk`; idle level is 1.
- `rst_BR`  input  1  from FSM; active-low hold/clear of the baud counter.
- `rst_bit_counter`  input  1  from FSM; active-low clear of the bit counter.
- `bit_count_enable`  input  1  from FSM; increments the bit counter.
- `sample_o`  input  1  from FSM; shifts `rx_sync` into the shift register.
- `enable_out_reg`  input  1  from FSM; loads the output register.
- `clr_rx_flag`  input  1  from core; clears `rx_ready` and `overrun_error`.
- `rx_sync`  output  1  synchronized `rx`, drives the FSM `rx` input.
- `end_half_time_o`  output  1  half-bit tick, drives FSM `end_half_time_i`.
- `end_bit_time_o`  output  1  full-bit tick, drives FSM `end_bit_time_i`.
- `Rx_bit_Count`  output  4  bit counter value.
- `Rx_Data`  output  8  received byte.
- `parity_error`  output  1  parity mismatch on the last latched frame.
- `framing_error`  output  1  stop bit sampled 0 on the last latched frame.
- `overrun_error`  output  1  sticky; a frame was latched while `rx_ready` was still 1.
- `rx_ready`  output  1  a new byte is available.

## Operation
- **Synchronizer:** two flops, both reset to 1. `rx_sync` is `rx` delayed by 2 clocks.
- **Baud counter:** `cnt` is 16 bits, with `HALF = BIT_CYCLES/2` (integer division).
  - While `rst_BR` = 0: `cnt` = 0.
  - Otherwise: `cnt` increments each clock and wraps from `BIT_CYCLES-1` to 0.
  - `end_half_time_o` = (`cnt == HALF-1`) and `rst_BR`. It is combinational and high for 1 cycle.
  - `end_bit_time_o` = (`cnt == BIT_CYCLES-1`) and `rst_BR`. It is high for 1 cycle, once per bit.
- **Bit counter:**
  - While `rst_bit_counter` = 0: `Rx_bit_Count` = 0.
  - Otherwise: increments when `bit_count_enable` = 1 and saturates at 15.
  - If `rst_bit_counter` = 0 and `bit_count_enable` = 1 in the same cycle, the clear wins.
- **Shift register:** `shreg` is 9 bits. On `sample_o`: `shreg <= {rx_sync, shreg[8:1]}`.
  - After 9 samples, `shreg[7:0]` holds the data (the first bit received is the LSB) and `shreg[8]` holds the parity bit.
  - `shreg` is not cleared between frames; each frame overwrites all 9 bits.
- **Stop capture:** `stop_bit` register, reset value 1. It loads `rx_sync` when `end_half_time_o` = 1, `Rx_bit_Count` = 9 and `rst_bit_counter` = 1.
- **Output register, loaded on `enable_out_reg` = 1:**
  - `Rx_Data <= shreg[7:0]`.
  - `parity_error <= ^shreg[8:0] ^ PARITY_ODD`.
  - `framing_error <= ~stop_bit`.
  - `rx_ready <= 1`.
  - `overrun_error <= overrun_error | rx_ready`, evaluated with the pre-load value of `rx_ready`.
- **Flag clear:**
  - `clr_rx_flag` = 1 clears `rx_ready` and `overrun_error`.
  - If `clr_rx_flag` and `enable_out_reg` are high in the same cycle, the load wins: `rx_ready` = 1 and `overrun_error` = 0, because the old frame was consumed.
  - `Rx_Data`, `parity_error` and `framing_error` hold until the next load.

## Timing
- **Reset values:**
  - `rx_sync` = 1, `end_half_time_o` = 0, `end_bit_time_o` = 0, `Rx_bit_Count` = 0.
  - `Rx_Data` = 0x00, `parity_error` = 0, `framing_error` = 0, `overrun_error` = 0, `rx_ready` = 0.
  - Internal: `cnt` = 0, `shreg` = 0, `stop_bit` = 1.
- **Reset mid-frame:** all registers return to their reset values immediately (asynchronous). No partial byte is ever latched.
- **Latency:**
  - `rx` edge to `rx_sync`: 2 clocks.
  - `rst_BR` rising to first `end_half_time_o`: `HALF` clocks.
  - `rst_BR` rising to first `end_bit_time_o`: `BIT_CYCLES` clocks.
  - `enable_out_reg` high to `rx_ready` visible: 1 clock.
- **Frame length:** one frame from the start edge at `rx_sync` is about 11 × `BIT_CYCLES` clocks.
- **Sample points:** samples land at mid-bit, `HALF` cycles after each bit boundary.
- **Tick dependence:** ticks depend combinationally on `rst_BR`. When `rst_BR` is 0, both ticks are 0.
- **FSM loop:** the FSM loop is registered, so the design has no combinational loop.

## Test plan
- **Baud ticks:** `BIT_CYCLES` = 8. Hold `rst_BR` = 0, then release it. Expect `end_half_time_o` on cycles 4, 12, 20 and `end_bit_time_o` on cycles 8, 16, 24 after release.
- **Good frame:** with the FSM attached and even parity, send 0xA5, parity 0, stop 1. Expect `Rx_Data` = 0xA5, `rx_ready` = 1, and `parity_error` = `framing_error` = `overrun_error` = 0.
- **Bad parity:** send 0x01 with parity 0 (even parity requires 1). Expect `parity_error` = 1 and `Rx_Data` = 0x01. Repeat with `PARITY_ODD` = 1: expect `parity_error` = 0.
- **Framing error:** send 0x3C with the stop bit forced to 0. Expect `framing_error` = 1 and `Rx_Data` = 0x3C.
- **Overrun:** receive 0x11 and 0x22 without asserting `clr_rx_flag`. Expect `Rx_Data` = 0x22 and `overrun_error` = 1. Pulse `clr_rx_flag`: expect `rx_ready` = 0 and `overrun_error` = 0. Assert `clr_rx_flag` on the same cycle as a load: expect `rx_ready` = 1.
- **Reset mid-frame:** assert `rst` after the 4th data bit. Expect all outputs at their reset values within the same cycle. Then send 0x5A cleanly: expect `Rx_Data` = 0x5A with no error flags.
